// File: rtl/spi_oled_pkg.sv
// Shared constants, entry layout and hex helper for the SPI transfer log.
// SPI_OLED_LOG_MISMATCH_EN adds a tx/rx mismatch bit to each logged entry.
package spi_oled_pkg;

  localparam int CHAR_W     = 8;
  localparam int LINE_CHARS = 16;
  localparam int LINE_W     = CHAR_W * LINE_CHARS;

  localparam logic [CHAR_W-1:0] ASCII_HASH  = 8'h23;
  localparam logic [CHAR_W-1:0] ASCII_T     = 8'h54;
  localparam logic [CHAR_W-1:0] ASCII_R     = 8'h52;
  localparam logic [CHAR_W-1:0] ASCII_BANG  = 8'h21;
  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;

  typedef struct packed {
    logic [7:0] seq;
    logic [7:0] tx;
    logic [7:0] rx;
`ifdef SPI_OLED_LOG_MISMATCH_EN
    logic       mis;
`endif
  } entry_t;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [CHAR_W-1:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/oled_line_fmt.sv
// Combinational renderer: one logged entry -> 16-char ASCII line "#SS TXX RYY     ".
// With SPI_OLED_LOG_MISMATCH_EN defined, char 14 shows '!' on a tx/rx mismatch.
module oled_line_fmt
  import spi_oled_pkg::*;
#(
  parameter logic [CHAR_W-1:0] FILL_CHAR = 8'h20
) (
  input  entry_t            entry,
  output logic [LINE_W-1:0] line
);

  logic [CHAR_W-1:0] flag_char;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    flag_char = FILL_CHAR;
`ifdef SPI_OLED_LOG_MISMATCH_EN
    if (entry.mis) flag_char = ASCII_BANG;
`endif
    line = {ASCII_HASH, hex_to_ascii(entry.seq[7:4]), hex_to_ascii(entry.seq[3:0]), ASCII_SPACE,
            ASCII_T,    hex_to_ascii(entry.tx[7:4]),  hex_to_ascii(entry.tx[3:0]),  ASCII_SPACE,
            ASCII_R,    hex_to_ascii(entry.rx[7:4]),  hex_to_ascii(entry.rx[3:0]),
            FILL_CHAR, FILL_CHAR, FILL_CHAR, flag_char, FILL_CHAR};
  end

endmodule

// File: rtl/spi_oled_log.sv
// Logs completed SPI transfers through a small FIFO and scrolls them onto four OLED text lines.
// Optional build macro: SPI_OLED_LOG_MISMATCH_EN (flags tx/rx mismatches in char 14).
module spi_oled_log
  import spi_oled_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter logic [CHAR_W-1:0] FILL_CHAR = 8'h20
) (
  input  logic                     GCLK,
  input  logic                     RST,
  input  logic                     xfer_done,
  input  logic [7:0]               tx_byte,
  input  logic [7:0]               rx_byte,
  input  logic                     hold,
  input  logic                     clr,
  output logic [LINE_W-1:0]        str0,
  output logic [LINE_W-1:0]        str1,
  output logic [LINE_W-1:0]        str2,
  output logic [LINE_W-1:0]        str3,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [LINE_W-1:0] BLANK  = {LINE_CHARS{FILL_CHAR}};

  entry_t              mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [7:0]          seq;
  entry_t              new_entry, fmt_entry;
  logic                fmt_valid;
  logic [LINE_W-1:0]   fmt_line;
  logic                full, push, pop, flush;

  always_comb begin
    flush = RST || clr;
    full  = (fifo_level == FULL_LVL);
    // A pop needs a non-empty FIFO at cycle start, so an empty FIFO never bypasses.
    pop   = !hold && (fifo_level != '0);
    push  = xfer_done && (!full || pop);

    new_entry     = '0;
    new_entry.seq = seq;
    new_entry.tx  = tx_byte;
    new_entry.rx  = rx_byte;
`ifdef SPI_OLED_LOG_MISMATCH_EN
    new_entry.mis = (tx_byte != rx_byte);
`endif
  end

  // NOTE: FIFO storage has no reset; pointers and level define validity, so stale data is never read.
  always_ff @(posedge GCLK) begin
    if (push && !flush) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge GCLK) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
      fmt_valid  <= 1'b0;
      fmt_entry  <= '0;
      str0       <= BLANK;
      str1       <= BLANK;
      str2       <= BLANK;
      str3       <= BLANK;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 8'd1;
      end
      if (xfer_done && !push) overflow <= 1'b1;

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase

      fmt_valid <= pop;
      if (pop) begin
        fmt_entry <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end

      // Scroll is deliberately not gated by hold so an in-flight pop always lands.
      if (fmt_valid) begin
        str3 <= str2;
        str2 <= str1;
        str1 <= str0;
        str0 <= fmt_line;
      end
    end
  end

  oled_line_fmt #(.FILL_CHAR(FILL_CHAR)) u_fmt (
    .entry (fmt_entry),
    .line  (fmt_line)
  );

endmodule

// File: tb/tb_spi_oled_log.sv
// Directed self-checking bench for spi_oled_log (DEPTH=4, FILL_CHAR=space).
// Honours SPI_OLED_LOG_MISMATCH_EN when computing expected char 14.
module tb_spi_oled_log;

  localparam logic [7:0]   FILL  = 8'h20;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic         GCLK = 1'b0;
  logic         RST, xfer_done, hold, clr;
  logic [7:0]   tx_byte, rx_byte;
  logic [127:0] str0, str1, str2, str3;
  logic         overflow;
  logic [2:0]   fifo_level;

  int checks = 0;
  int errors = 0;

  spi_oled_log #(.DEPTH(4), .FILL_CHAR(FILL)) dut (
    .GCLK       (GCLK),
    .RST        (RST),
    .xfer_done  (xfer_done),
    .tx_byte    (tx_byte),
    .rx_byte    (rx_byte),
    .hold       (hold),
    .clr        (clr),
    .str0       (str0),
    .str1       (str1),
    .str2       (str2),
    .str3       (str3),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 GCLK = ~GCLK;

  task automatic step();
    @(posedge GCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, ".str0"}, str0, BLANK);
    check({tag, ".str1"}, str1, BLANK);
    check({tag, ".str2"}, str2, BLANK);
    check({tag, ".str3"}, str3, BLANK);
  endtask

  task automatic check_status(input string tag, input logic [2:0] lvl, input logic ovf);
    check({tag, ".level"}, 128'(fifo_level), 128'(lvl));
    check({tag, ".overflow"}, 128'(overflow), 128'(ovf));
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n) - 8'd10;
  endfunction

  function automatic logic [127:0] exp_line(input logic [7:0] s, input logic [7:0] t, input logic [7:0] r);
    logic [7:0] c14;
    c14 = FILL;
`ifdef SPI_OLED_LOG_MISMATCH_EN
    if (t != r) c14 = 8'h21;
`endif
    return {8'h23, hx(s[7:4]), hx(s[3:0]), 8'h20, 8'h54, hx(t[7:4]), hx(t[3:0]), 8'h20,
            8'h52, hx(r[7:4]), hx(r[3:0]), FILL, FILL, FILL, c14, FILL};
  endfunction

  task automatic xfer(input logic [7:0] t, input logic [7:0] r);
    xfer_done = 1'b1;
    tx_byte   = t;
    rx_byte   = r;
    step();
    xfer_done = 1'b0;
  endtask

  initial begin
    logic [127:0] lit;
    RST = 1'b1; xfer_done = 1'b0; hold = 1'b0; clr = 1'b0; tx_byte = '0; rx_byte = '0;

    // Reset, then idle.
    repeat (3) step();
    RST = 1'b0;
    repeat (10) step();
    check_blank("reset");
    check_status("reset", 3'd0, 1'b0);

    // First transfer: latency N -> N+1 pop -> N+2 display.
    xfer(8'hA5, 8'hA5);
    check_status("lat.push", 3'd1, 1'b0);
    check("lat.str0_before", str0, BLANK);
    step();
    check_status("lat.pop", 3'd0, 1'b0);
    check("lat.str0_pop", str0, BLANK);
    step();
    lit = "#00 TA5 RA5     ";
    check("first.str0", str0, lit);
    check("first.str1", str1, BLANK);
    check("first.str3", str3, BLANK);

    // Second transfer scrolls the first down.
    xfer(8'h3C, 8'hC3);
    step(); step();
    check("second.str0", str0, exp_line(8'h01, 8'h3C, 8'hC3));
    check("second.str1", str1, lit);
    check("second.str2", str2, BLANK);

    // Clear, then hold with six back-to-back transfers: four accepted, two dropped.
    clr = 1'b1; step(); clr = 1'b0;
    check_blank("clr1");
    check_status("clr1", 3'd0, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 6; i++) xfer(8'h10 + 8'(i), 8'h80 + 8'(i));
    check_status("hold.full", 3'd4, 1'b1);
    step();
    check_blank("hold.frozen");
    hold = 1'b0;
    step();
    check_status("drain.first_pop", 3'd3, 1'b1);
    check("drain.str0_pending", str0, BLANK);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("drain.str0_%0d", i), str0, exp_line(8'(i), 8'h10 + 8'(i), 8'h80 + 8'(i)));
    end
    check("drain.str3", str3, exp_line(8'h00, 8'h10, 8'h80));
    check_status("drain.end", 3'd0, 1'b1);

    // Dropped transfers did not advance seq: the next one is #04.
    xfer(8'hAA, 8'hBB);
    step(); step();
    check("seq_after_drop", str0, exp_line(8'h04, 8'hAA, 8'hBB));

    // Full FIFO, hold released with a push in the same cycle as the first pop.
    clr = 1'b1; step(); clr = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) xfer(8'hC0 + 8'(i), 8'hC0 + 8'(i));
    check_status("full_pop.before", 3'd4, 1'b0);
    hold = 1'b0;
    xfer(8'h55, 8'h66);
    check_status("full_pop.same_cycle", 3'd4, 1'b0);
    repeat (5) step();
    check("full_pop.str0", str0, exp_line(8'h04, 8'h55, 8'h66));
    check("full_pop.str1", str1, exp_line(8'h03, 8'hC3, 8'hC3));
    check_status("full_pop.end", 3'd0, 1'b0);

    // clr together with xfer_done mid-drain, overflow set beforehand.
    hold = 1'b1;
    for (int i = 0; i < 6; i++) xfer(8'h40 + 8'(i), 8'h40 + 8'(i));
    check_status("clrmid.full", 3'd4, 1'b1);
    hold = 1'b0;
    step(); step();
    check("clrmid.str0", str0, exp_line(8'h05, 8'h40, 8'h40));
    clr = 1'b1;
    xfer(8'h99, 8'h77);
    clr = 1'b0;
    check_blank("clrmid");
    check_status("clrmid", 3'd0, 1'b0);
    step();
    check_blank("clrmid.next");
    xfer(8'h12, 8'h34);
    step(); step();
    check("clrmid.restart", str0, exp_line(8'h00, 8'h12, 8'h34));

    // 258 back-to-back transfers: seq wraps FF -> 00 -> 01 at one line per cycle.
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 258; i++) xfer(8'(i), 8'(i));
    check_status("wrap.steady", 3'd1, 1'b0);
    step();
    check("wrap.str0_00", str0, exp_line(8'h00, 8'h00, 8'h00));
    check("wrap.str1_ff", str1, exp_line(8'hFF, 8'hFF, 8'hFF));
    step();
    check("wrap.str0_01", str0, exp_line(8'h01, 8'h01, 8'h01));
    check("wrap.str1_00", str1, exp_line(8'h00, 8'h00, 8'h00));
    check("wrap.str2_ff", str2, exp_line(8'hFF, 8'hFF, 8'hFF));
    check_status("wrap.end", 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_oled_log.md
Name: spi_oled_log

Overview:
- Downstream consumer of the SPI master/slave loopback.
- Captures each completed transfer as a {master TX byte, slave RX byte} pair and buffers it in a small FIFO.
- Renders each pair as one 16-character ASCII line and scrolls it onto four 128-bit OLED string outputs, newest on line 0.
- Sits between the SPI block's transfer-done strobe and the OLED text driver.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- FILL_CHAR, 8'h20, ASCII used for blank characters and reset contents.

Ports:
- GCLK  in  1  system clock
- RST  in  1  synchronous reset, active high
- xfer_done  in  1  one-cycle strobe: transfer complete, tx_byte/rx_byte valid this cycle
- tx_byte  in  8  byte the master shifted out
- rx_byte  in  8  byte the slave received
- hold  in  1  1 = freeze display; FIFO keeps accepting
- clr  in  1  synchronous clear of display, FIFO, sequence counter and overflow flag
- str0  out  128  line 0 (newest); char 0 in [127:120], char 15 in [7:0]
- str1  out  128  line 1
- str2  out  128  line 2
- str3  out  128  line 3 (oldest)
- overflow  out  1  sticky: a transfer was dropped because the FIFO was full
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: on RST=1 at a GCLK edge (synchronous, active high):
  - str0..str3 = {16{FILL_CHAR}}
  - overflow=0, fifo_level=0, seq=0, formatter stage invalid
- Priority: RST > clr > normal operation. clr behaves like reset for all state; an xfer_done in the same cycle is discarded and seq is not incremented.
- Push:
  - On xfer_done, write {seq, tx_byte, rx_byte} if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - seq (8-bit) increments only on an accepted push and wraps 8'hFF -> 8'h00.
- Drop:
  - If full with no same-cycle pop, the entry is discarded, seq is unchanged, and overflow is set.
  - overflow clears only on RST or clr.
- Pop: when hold=0 and the FIFO is non-empty, one entry per cycle is popped into the format register (stage F).
- Scroll: the cycle after F is valid:
  - str3<=str2, str2<=str1, str1<=str0, str0<=formatted line.
  - The scroll is not gated by hold, so a pop already in flight completes.
- Latency: xfer_done sampled at edge N, FIFO empty, hold=0:
  - entry visible (fifo_level=1) after edge N;
  - popped at edge N+1;
  - str0 updated at edge N+2.
- Throughput: sustained one line per cycle.
- Empty FIFO with simultaneous push and pop: not possible; a pop requires a non-empty FIFO at the cycle start, so the entry is not bypassed.
- Hold: while hold=1, no pops occur and the strings are stable except for a single in-flight scroll. Releasing hold drains one entry per cycle.
- Line format, chars 0..15:
  - '#', seq hi hex, seq lo hex, ' ', 'T', tx hi, tx lo, ' ', 'R', rx hi, rx lo, then 5 × FILL_CHAR.
- Hex to ASCII: 0-9 -> 8'h30-8'h39; A-F -> uppercase 8'h41-8'h46.
- fifo_level: registered; updates on the same edge as the push/pop.

Optional Feature:
- Macro: SPI_OLED_LOG_MISMATCH_EN
- Defined:
  - char 14 = '!' (8'h21) when tx_byte != rx_byte, else FILL_CHAR;
  - the comparison is made at push time and stored as a 1-bit FIFO field.
- Undefined: char 14 = FILL_CHAR always; no extra FIFO bit.

Decomposition:
- Package spi_oled_pkg:
  - constants: CHAR_W=8, LINE_CHARS=16, LINE_W=128, ASCII codes ('#','T','R','!', space);
  - hex_to_ascii(4-bit) function;
  - entry struct/typedef {seq, tx, rx[, mis]}.
- One sub-module, oled_line_fmt: combinational entry -> 128-bit line. The FIFO stays inline.

Test Plan:
- Reset then idle 10 cycles -> all str = 128'h2020…20, overflow=0, fifo_level=0.
- xfer_done with tx=8'hA5, rx=8'hA5 -> 2 cycles later str0 = "#00 TA5 RA5     ", str1..3 blank. A second event tx=8'h3C, rx=8'hC3 -> str0="#01 T3C RC3     ", str1 = previous str0. With MISMATCH_EN, char 14 of the second line = '!'.
- hold=1, 6 back-to-back xfer_done, DEPTH=4 -> fifo_level=4, overflow=1, seq ends at 4. Release hold -> 4 lines "#00".."#03" scroll in on consecutive cycles: str0="#03…", str3="#00…".
- 256+2 transfers, hold=0 -> seq wraps: str0 shows "#01" after "#00" following "#FF".
- FIFO full, hold dropped, xfer_done in the same cycle as the first pop -> push accepted, fifo_level stays 4, overflow stays 0.
- clr and xfer_done asserted together mid-drain -> all strings blank next cycle, fifo_level=0, overflow=0, the next transfer shows "#00".
